// File: rtl/rr_grant_rotl_num_vc.sv
// Registered round-robin VC grant with a valid/ack handshake and a rotating priority pointer.
// Optional macro RR_NUM_VC_GRANT_LOCK_EN adds grant_lock to hold a grant across acks.

module rr_grant_rotl_num_vc_tap #(
  parameter int NUM_VC  = 4,
  parameter int bits_VC = 2,
  parameter int LANE    = 0
) (
  input  logic [NUM_VC-1:0]  request,
  input  logic [bits_VC-1:0] ptr,
  output logic               rot_bit
);
  localparam logic [bits_VC:0] NVC = (bits_VC+1)'(NUM_VC);

  logic [bits_VC:0] src;

  // Lane LANE of the right-rotated vector comes from request[(LANE + ptr) mod NUM_VC].
  always_comb begin
    src = (bits_VC+1)'(LANE) + {1'b0, ptr};
    if (src >= NVC) src = src - NVC;
    rot_bit = 1'b0;
    for (int j = 0; j < NUM_VC; j++)
      if (src == (bits_VC+1)'(j)) rot_bit = request[j];
  end
endmodule

module rr_grant_rotl_num_vc #(
  parameter int NUM_VC = 4,
  parameter int NUM_VN = 3,
  localparam int bits_VC = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic               clk,
  input  logic               rst_p,
  input  logic [NUM_VC-1:0]  request,
  input  logic               grant_ack,
`ifdef RR_NUM_VC_GRANT_LOCK_EN
  input  logic               grant_lock,
`endif
  output logic [NUM_VC-1:0]  grant,
  output logic               grant_valid,
  output logic [bits_VC-1:0] grant_idx,
  output logic [bits_VC-1:0] ptr
);
  localparam logic [bits_VC:0] NVC = (bits_VC+1)'(NUM_VC);

  if (NUM_VC < 1 || NUM_VN < 1) begin : g_param_err
    $error("rr_grant_rotl_num_vc: NUM_VC and NUM_VN must be >= 1");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [NUM_VC-1:0]    grant_q, grant_d, win_grant, rot;
  logic [bits_VC-1:0]   idx_q, idx_d, ptr_q, ptr_d, win, real_idx, ptr_inc;
  logic [bits_VC:0]     real_sum;
  logic                 held, lock;

`ifdef RR_NUM_VC_GRANT_LOCK_EN
  assign lock = grant_lock;
`else
  assign lock = 1'b0;
`endif

  for (genvar i = 0; i < NUM_VC; i++) begin : g_lane
    rr_grant_rotl_num_vc_tap #(.NUM_VC(NUM_VC), .bits_VC(bits_VC), .LANE(i)) u_tap (
      .request (request),
      .ptr     (ptr_q),
      .rot_bit (rot[i])
    );
  end

  // Lowest set bit of the rotated vector is the winner relative to ptr.
  always_comb begin
    win = '0;
    for (int i = NUM_VC-1; i >= 0; i--)
      if (rot[i]) win = bits_VC'(i);
  end

  // Rotating onehot(win) left by ptr lands on (win + ptr) mod NUM_VC.
  always_comb begin
    real_sum = {1'b0, win} + {1'b0, ptr_q};
    if (real_sum >= NVC) real_sum = real_sum - NVC;
    real_idx = real_sum[bits_VC-1:0];
    for (int j = 0; j < NUM_VC; j++)
      win_grant[j] = (real_idx == bits_VC'(j));
  end

  assign ptr_inc = (idx_q == bits_VC'(NUM_VC-1)) ? '0 : idx_q + bits_VC'(1);
  // grant_q is one-hot on the held VC, so this is request[grant_idx].
  assign held    = |(request & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|request) begin
          grant_d = win_grant;
          idx_d   = real_idx;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (grant_ack && !lock) begin
          ptr_d   = ptr_inc;
          grant_d = '0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (!held) begin
          grant_d = '0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state_q == GRANTED);
  assign grant_idx   = idx_q;
  assign ptr         = ptr_q;
endmodule
